// File: rtl/axil_pattern_master.sv
// AXI4-Lite self-test master: writes an incrementing pattern to C_NUM_WORDS
// consecutive words, reads each back, and counts mismatches and error responses.
module axil_pattern_master #(
   parameter int unsigned                          C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned                          C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned                          C_NUM_WORDS        = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        C_BASE_ADDR        = 32'h0000_0000,
   parameter logic [C_M_AXI_DATA_WIDTH-1:0]        C_START_DATA       = 32'h0000_0001
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [7:0]                        err_cnt,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int unsigned BYTE_SHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);
   localparam logic [8:0]  LAST_IDX   = 9'(C_NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FIN
   } state_t;

   state_t                          state, state_d;
   logic [8:0]                      idx, idx_d;
   logic                            aw_done, aw_done_d, w_done, w_done_d;
   logic                            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, araddr_d, word_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_d, exp_data;
   logic                            busy_d, done_d, pass_d, err_hit, last;
   logic [7:0]                      err_d;

   assign M_AXI_AWPROT = '0;
   assign M_AXI_ARPROT = '0;
   assign M_AXI_WSTRB  = '1;

   assign word_addr = C_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx) << BYTE_SHIFT);
   assign exp_data  = C_START_DATA + C_M_AXI_DATA_WIDTH'(idx);
   assign last      = (idx == LAST_IDX);

   always_comb begin
      state_d   = state;
      idx_d     = idx;
      aw_done_d = aw_done;
      w_done_d  = w_done;
      awvalid_d = M_AXI_AWVALID;
      wvalid_d  = M_AXI_WVALID;
      bready_d  = M_AXI_BREADY;
      arvalid_d = M_AXI_ARVALID;
      rready_d  = M_AXI_RREADY;
      awaddr_d  = M_AXI_AWADDR;
      wdata_d   = M_AXI_WDATA;
      araddr_d  = M_AXI_ARADDR;
      busy_d    = busy;
      done_d    = done;
      pass_d    = pass;
      err_d     = err_cnt;
      err_hit   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_d   = WR_REQ;
               idx_d     = '0;
               err_d     = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         // Each channel raises VALID once per word and tracks its own completion,
         // so AW and W may handshake in either order or together.
         WR_REQ: begin
            if (!M_AXI_AWVALID && !aw_done) begin
               awvalid_d = 1'b1;
               awaddr_d  = word_addr;
            end else if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (!M_AXI_WVALID && !w_done) begin
               wvalid_d = 1'b1;
               wdata_d  = exp_data;
            end else if (M_AXI_WVALID && M_AXI_WREADY) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               bready_d  = 1'b0;
               err_hit   = (M_AXI_BRESP != 2'b00);
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (last) begin
                  idx_d   = '0;
                  state_d = RD_REQ;
               end else begin
                  idx_d   = idx + 9'd1;
                  state_d = WR_REQ;
               end
            end
         end
         RD_REQ: begin
            if (!M_AXI_ARVALID) begin
               arvalid_d = 1'b1;
               araddr_d  = word_addr;
            end else if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               rready_d = 1'b0;
               err_hit  = (M_AXI_RDATA != exp_data) || (M_AXI_RRESP != 2'b00);
               if (last) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx + 9'd1;
                  state_d = RD_REQ;
               end
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt == 8'd0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (err_hit && (err_cnt != 8'hFF)) begin
         err_d = err_cnt + 8'd1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= IDLE;
         idx           <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         M_AXI_AWADDR  <= C_BASE_ADDR;
         M_AXI_ARADDR  <= C_BASE_ADDR;
         M_AXI_WDATA   <= C_START_DATA;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
      end else begin
         state         <= state_d;
         idx           <= idx_d;
         aw_done       <= aw_done_d;
         w_done        <= w_done_d;
         M_AXI_AWVALID <= awvalid_d;
         M_AXI_WVALID  <= wvalid_d;
         M_AXI_BREADY  <= bready_d;
         M_AXI_ARVALID <= arvalid_d;
         M_AXI_RREADY  <= rready_d;
         M_AXI_AWADDR  <= awaddr_d;
         M_AXI_ARADDR  <= araddr_d;
         M_AXI_WDATA   <= wdata_d;
         busy          <= busy_d;
         done          <= done_d;
         pass          <= pass_d;
         err_cnt       <= err_d;
      end
   end

endmodule

// File: tb/tb_axil_pattern_master.sv
// Bench for axil_pattern_master: behavioural BRAM slave with stall/fault knobs,
// a transaction-level model of the run, and directed scenarios.
module tb_axil_pattern_master;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass;
   logic [7:0]  err_cnt;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axil_pattern_master #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_NUM_WORDS(N),
      .C_BASE_ADDR(32'h0000_0000),
      .C_START_DATA(32'h0000_0001)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n), .start(start),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // ---------------- slave ----------------
   logic        stall_mode = 1'b0;
   int          corrupt_word = -1, bresp_err_word = -1, rresp_err_word = -1;
   logic [31:0] mem [0:15];
   logic [31:0] aw_q, w_q;
   logic        aw_have, w_have;
   int          aw_wait, w_wait, ar_wait;

   wire         aw_fire = awvalid && awready;
   wire         w_fire  = wvalid && wready;
   wire         ar_fire = arvalid && arready;
   wire [31:0]  aw_eff  = aw_fire ? awaddr : aw_q;
   wire [31:0]  w_eff   = w_fire ? wdata : w_q;
   wire [3:0]   widx    = aw_eff[5:2];
   wire [3:0]   ridx    = araddr[5:2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= !stall_mode; wready <= !stall_mode; arready <= !stall_mode;
         aw_wait <= 2; w_wait <= 0; ar_wait <= 1;
         aw_have <= 1'b0; w_have <= 1'b0; aw_q <= '0; w_q <= '0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      end else begin
         if (aw_fire) aw_q <= awaddr;
         if (w_fire)  w_q  <= wdata;
         if ((aw_have || aw_fire) && (w_have || w_fire)) begin
            mem[widx] <= w_eff;
            bvalid    <= 1'b1;
            bresp     <= (int'(widx) == bresp_err_word) ? 2'b10 : 2'b00;
            aw_have   <= 1'b0;
            w_have    <= 1'b0;
         end else begin
            if (aw_fire) aw_have <= 1'b1;
            if (w_fire)  w_have  <= 1'b1;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (ar_fire) begin
            rvalid <= 1'b1;
            rresp  <= 2'b00;
            rdata  <= mem[ridx];
            if (int'(ridx) == corrupt_word) rdata <= 32'hDEAD_BEEF;
            if (int'(ridx) == rresp_err_word) begin
               rresp <= 2'b10;
               rdata <= ~mem[ridx];
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
         // AW waits 1..5 cycles, W 0 cycles: W always wins in stall mode
         if (stall_mode) begin
            if (aw_fire) begin awready <= 1'b0; aw_wait <= int'($urandom_range(1, 5)); end
            else if (awvalid && !awready) begin
               if (aw_wait == 0) awready <= 1'b1; else aw_wait <= aw_wait - 1;
            end
            if (w_fire) begin wready <= 1'b0; w_wait <= 0; end
            else if (wvalid && !wready) begin
               if (w_wait == 0) wready <= 1'b1; else w_wait <= w_wait - 1;
            end
            if (ar_fire) begin arready <= 1'b0; ar_wait <= int'($urandom_range(0, 5)); end
            else if (arvalid && !arready) begin
               if (ar_wait == 0) arready <= 1'b1; else ar_wait <= ar_wait - 1;
            end
         end else begin
            awready <= 1'b1; wready <= 1'b1; arready <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model of one run.
   logic        m_busy, m_done, fin_pending;
   int          m_err, aw_n, w_n, b_n, ar_n, r_n;
   logic        p_aw, p_w, p_ar;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   task automatic model_clear();
      m_busy = 0; m_done = 0; fin_pending = 0; m_err = 0;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
   endtask

   task automatic monitor();
      if (!rst_n) begin
         model_clear();
         return;
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("pass", pass, m_done && (m_err == 0));
      if (m_done) chk("err_cnt", err_cnt, m_err);
      if (p_aw) chk("aw_hold", {awvalid, awaddr[30:0]}, {1'b1, p_awaddr[30:0]});
      if (p_w)  chk("w_hold",  {wvalid, wdata[30:0]},  {1'b1, p_wdata[30:0]});
      if (p_ar) chk("ar_hold", {arvalid, araddr[30:0]}, {1'b1, p_araddr[30:0]});
      if (arvalid) chk("ar_after_writes", b_n, N);
      if (aw_fire) begin chk("aw_addr", awaddr, 32'(aw_n * 4)); aw_n++; end
      if (w_fire)  begin chk("w_data", wdata, 32'(w_n + 1)); w_n++; end
      if (ar_fire) begin chk("ar_addr", araddr, 32'(ar_n * 4)); ar_n++; end
      if (bvalid && bready) begin
         if (bresp != 2'b00 && m_err < 255) m_err++;
         b_n++;
      end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata;
      p_ar = arvalid && !arready; p_araddr = araddr;
      if (fin_pending) begin
         fin_pending = 0; m_busy = 0; m_done = 1;
      end
      if (rvalid && rready) begin
         if ((rdata != 32'(r_n + 1) || rresp != 2'b00) && m_err < 255) m_err++;
         r_n++;
         if (r_n == N) fin_pending = 1;
      end
      if (start && !m_busy) begin
         m_busy = 1; m_done = 0; m_err = 0;
         aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      end
   endtask

   task automatic tick();
      monitor();
      @(negedge clk);
   endtask

   task automatic run(input int budget, input int pulse_at, output int n);
      start = 1'b1; tick(); start = 1'b0;
      chk("start_accept", {busy, done}, 2'b10);
      n = 0;
      while (!done && n < budget) begin
         start = (n == pulse_at); tick(); start = 1'b0;
         n++;
      end
      chk("done_reached", done, 1'b1);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
   endtask

   int n;

   initial begin
      model_clear();
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 8'h00);
      chk("rst_err", err_cnt, 0);
      chk("rst_awaddr", awaddr, 32'h0);
      chk("rst_wdata", wdata, 32'h1);
      chk("fixed_prot_strb", {awprot, arprot, wstrb}, 10'b000_000_1111);
      @(negedge clk);
      reset_dut();

      // zero-wait slave
      run(200, -1, n);
      chk("latency", n, 25);
      chk("pass_t1", {done, pass, err_cnt}, {2'b11, 8'd0});
      for (int i = 0; i < N; i++) chk("mem_word", mem[i], 32'(i + 1));
      repeat (3) tick();

      // stalled slave, W before AW
      stall_mode = 1'b1; reset_dut();
      run(1000, -1, n);
      chk("pass_t2", {done, pass, err_cnt}, {2'b11, 8'd0});
      for (int i = 0; i < N; i++) chk("mem_word_stall", mem[i], 32'(i + 1));

      // corrupted readback of word 2
      stall_mode = 1'b0; corrupt_word = 2; reset_dut();
      run(200, -1, n);
      chk("corrupt", {done, pass, err_cnt}, {2'b10, 8'd1});
      corrupt_word = -1;

      // BRESP error on word 0, RRESP error plus bad data on word 3
      bresp_err_word = 0; rresp_err_word = 3; reset_dut();
      run(200, -1, n);
      chk("resp_errs", {done, pass, err_cnt}, {2'b10, 8'd2});
      bresp_err_word = -1; rresp_err_word = -1;

      // async reset while in RD_DATA
      reset_dut();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!rready && n < 100) begin tick(); n++; end
      chk("reach_rd_data", rready, 1'b1);
      rst_n = 1'b0; #1;
      chk("midrst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 8'h00);
      chk("midrst_err", err_cnt, 0);
      @(negedge clk); tick(); rst_n = 1'b1;
      repeat (4) begin
         tick();
         chk("idle_after_rst", {awvalid, wvalid, bready, arvalid, rready, busy}, 6'b0);
      end
      run(200, -1, n);
      chk("pass_after_rst", {done, pass, err_cnt}, {2'b11, 8'd0});

      // start while busy is ignored; start while done begins a new run
      run(200, 5, n);
      chk("latency_ignore_start", n, 25);
      chk("pass_t6a", {done, pass}, 2'b11);
      run(200, -1, n);
      chk("latency_rerun", n, 25);
      chk("pass_t6b", {done, pass, err_cnt}, {2'b11, 8'd0});
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
